// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   op_e       : pipeline load/store opcodes (LB..SW)
//   state_e    : sequencing states of mem_access_unit
//   WORD_BYTES : width of one data_memory access in bytes
package mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD,
    ST_ST,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle between the pipeline / data_memory side and mem_access_unit.
//   Request side : req, op, addr, wdata  ->  busy, done, rdata, addr_err
//   Memory side  : mem_address, mem_read, mem_write, mem_write_data -> mem_out
// Modports:
//   slave  : the load/store unit itself
//   master : the surrounding pipeline stage plus data_memory
interface mem_access_unit_if;
  import mem_pkg::*;

  logic        req;
  op_e         op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_out;

  modport slave (
    input  req, op, addr, wdata, mem_out,
    output busy, done, rdata, addr_err,
           mem_address, mem_read, mem_write, mem_write_data
  );

  modport master (
    output req, op, addr, wdata, mem_out,
    input  busy, done, rdata, addr_err,
           mem_address, mem_read, mem_write, mem_write_data
  );

endinterface

// File: rtl/byte_lane_unit.sv
// Combinational big-endian byte-lane logic for the load/store unit.
//   Load path : selects the byte/halfword at off from mem_out and sign- or
//               zero-extends it into rdata_next (LW passes the word through).
//   Store path: merges wdata into word at the lane selected by off for
//               SB/SH; other ops return word unchanged.
// Ports:
//   mem_out    in  32  word read from data_memory
//   op         in   3  latched opcode
//   off        in   2  byte offset within the word
//   rdata_next out 32  extended load result
//   word       in  32  previously read word (read-modify-write)
//   wdata      in  16  right-aligned store data (only the low half matters)
//   merged     out 32  word to write back
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] mem_out,
  input  op_e         op,
  input  logic [1:0]  off,
  output logic [31:0] rdata_next,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] merged
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lane_byte = mem_out[31:24];
    unique case (off)
      2'd0: lane_byte = mem_out[31:24];
      2'd1: lane_byte = mem_out[23:16];
      2'd2: lane_byte = mem_out[15:8];
      2'd3: lane_byte = mem_out[7:0];
    endcase
    // Halfword ops are only issued with off 0 or 2, so off[1] picks the lane.
    lane_half = off[1] ? mem_out[15:0] : mem_out[31:16];

    rdata_next = mem_out;
    case (op)
      OP_LB:   rdata_next = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  rdata_next = {24'h0, lane_byte};
      OP_LH:   rdata_next = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  rdata_next = {16'h0, lane_half};
      default: rdata_next = mem_out;
    endcase
  end

  always_comb begin
    merged = word;
    case (op)
      OP_SB: begin
        unique case (off)
          2'd0: merged[31:24] = wdata[7:0];
          2'd1: merged[23:16] = wdata[7:0];
          2'd2: merged[15:8]  = wdata[7:0];
          2'd3: merged[7:0]   = wdata[7:0];
        endcase
      end
      OP_SH: begin
        if (off[1]) merged[15:0]  = wdata;
        else        merged[31:16] = wdata;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU memory stage and data_memory.
// Turns byte/halfword/word load/store requests into word-aligned accesses;
// sub-word stores are done as read-modify-write. Misaligned or out-of-range
// requests are answered with addr_err and never reach memory.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of mem_access_unit_if (request + data_memory side)
// Parameter:
//   MEM_BYTES  byte capacity of data_memory; legal bases are 0..MEM_BYTES-4
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);

  localparam logic [31:0] MAX_BASE = 32'(MEM_BYTES - WORD_BYTES);

  state_e      state;
  op_e         op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_address_q;
  logic        busy_q;
  logic        done_q;
  logic        addr_err_q;
  logic        mem_read_q;
  logic        mem_write_q;

  logic [31:0] rdata_next;
  logic [31:0] merged;

  // Acceptance-time decode of the incoming request.
  logic [31:0] req_base;
  logic        req_err;

  assign req_base = {bus.addr[31:2], 2'b00};

  always_comb begin
    req_err = (req_base > MAX_BASE);
    case (bus.op)
      OP_LH, OP_LHU, OP_SH: req_err = req_err | bus.addr[0];
      OP_LW, OP_SW:         req_err = req_err | (bus.addr[1:0] != 2'b00);
      default:              ;
    endcase
  end

  byte_lane_unit u_lanes (
    .mem_out    (bus.mem_out),
    .op         (op_q),
    .off        (off_q),
    .rdata_next (rdata_next),
    .word       (merge_q),
    .wdata      (wdata_q[15:0]),
    .merged     (merged)
  );

  // Control outputs are registered alongside the state: each transition
  // loads the values the next state must present.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, the merge word included; none is a RAM.
    if (rst) begin
      state         <= ST_IDLE;
      op_q          <= OP_LB;
      off_q         <= 2'b00;
      wdata_q       <= '0;
      merge_q       <= '0;
      rdata_q       <= '0;
      mem_address_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      addr_err_q    <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            op_q       <= bus.op;
            off_q      <= bus.addr[1:0];
            wdata_q    <= bus.wdata;
            busy_q     <= 1'b1;
            addr_err_q <= req_err;
            if (req_err) begin
              state  <= ST_RESP;
              done_q <= 1'b1;
            end else begin
              mem_address_q <= req_base;
              case (bus.op)
                OP_SW: begin
                  state       <= ST_ST;
                  mem_write_q <= 1'b1;
                end
                OP_SB, OP_SH: begin
                  state      <= ST_RMW_RD;
                  mem_read_q <= 1'b1;
                end
                default: begin
                  state      <= ST_LD;
                  mem_read_q <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_LD: begin
          rdata_q       <= rdata_next;
          mem_read_q    <= 1'b0;
          mem_address_q <= '0;
          done_q        <= 1'b1;
          state         <= ST_RESP;
        end
        ST_ST: begin
          mem_write_q   <= 1'b0;
          mem_address_q <= '0;
          done_q        <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RMW_RD: begin
          // Address stays on base for the write-back cycle.
          merge_q     <= bus.mem_out;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          state       <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          mem_write_q   <= 1'b0;
          mem_address_q <= '0;
          done_q        <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write data is a state decode over registers: the merged word depends on
  // the merge register, which is only loaded on entry to RMW_WR.
  always_comb begin
    bus.mem_write_data = '0;
    case (state)
      ST_ST:     bus.mem_write_data = wdata_q;
      ST_RMW_WR: bus.mem_write_data = merged;
      default:   bus.mem_write_data = '0;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_read    = mem_read_q;
  // A write in flight when reset arrives must not reach memory.
  assign bus.mem_write   = mem_write_q & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural data_memory.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural data_memory: combinational read, clocked 4-byte write.
  logic [31:0] mem [256];
  assign bus.mem_out = mem[bus.mem_address[9:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        addr_err;
    int          lat;
    int          reads;
    int          writes;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } exp_t;

  exp_t sb[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: tracks each transaction from busy rising to done, then compares.
  logic        busy_prev = 1'b0;
  int          acc_cyc = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] wa = '0;
  logic [31:0] wd = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy && !busy_prev) begin
        acc_cyc = cyc;
        n_rd = 0;
        n_wr = 0;
      end
      if (bus.mem_read) n_rd++;
      if (bus.mem_write) begin
        n_wr++;
        wa = bus.mem_address;
        wd = bus.mem_write_data;
      end
      if (bus.mem_read || bus.mem_write)
        check("mem_align", {30'b0, bus.mem_address[1:0]}, 32'h0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done: got done=1 expected no transaction at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, ".rdata"}, bus.rdata, e.rdata);
          check({e.name, ".addr_err"}, {31'b0, bus.addr_err}, {31'b0, e.addr_err});
          check({e.name, ".latency"}, 32'(cyc - acc_cyc + 1), 32'(e.lat));
          check({e.name, ".reads"}, 32'(n_rd), 32'(e.reads));
          check({e.name, ".writes"}, 32'(n_wr), 32'(e.writes));
          if (e.writes > 0) begin
            check({e.name, ".wr_addr"}, wa, e.wr_addr);
            check({e.name, ".wr_data"}, wd, e.wr_data);
          end
        end
      end
    end
    busy_prev = bus.busy;
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (bus.busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) begin
      n_vec++;
      n_miss++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 50 cycles");
    end
  endtask

  task automatic expect_txn(string name, logic [31:0] rd, logic err, int lat,
                            int reads, int writes, logic [31:0] wad, logic [31:0] wdat);
    exp_t x;
    x.name = name; x.rdata = rd; x.addr_err = err; x.lat = lat;
    x.reads = reads; x.writes = writes; x.wr_addr = wad; x.wr_data = wdat;
    sb.push_back(x);
  endtask

  task automatic drive(op_e op, logic [31:0] a, logic [31:0] wdat);
    bus.req   = 1'b1;
    bus.op    = op;
    bus.addr  = a;
    bus.wdata = wdat;
  endtask

  task automatic issue(string name, op_e op, logic [31:0] a, logic [31:0] wdat,
                       logic [31:0] rd, logic err, int lat, int reads, int writes,
                       logic [31:0] wad, logic [31:0] wdx);
    wait_idle();
    expect_txn(name, rd, err, lat, reads, writes, wad, wdx);
    drive(op, a, wdat);
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'h8899AABB;
    bus.req = 1'b0; bus.op = OP_LB; bus.addr = '0; bus.wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy", {31'b0, bus.busy}, 32'h0);
    check("rst.mem_write", {31'b0, bus.mem_write}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.busy", {31'b0, bus.busy}, 32'h0);
    check("idle.done", {31'b0, bus.done}, 32'h0);
    check("idle.addr_err", {31'b0, bus.addr_err}, 32'h0);
    check("idle.mem_read", {31'b0, bus.mem_read}, 32'h0);
    check("idle.rdata", bus.rdata, 32'h0);
    check("idle.mem_address", bus.mem_address, 32'h0);
    check("idle.mem_write_data", bus.mem_write_data, 32'h0);

    // Loads from the preloaded word 0x8899AABB at 0x10.
    issue("lb_11",  OP_LB,  32'h11, 0, 32'hFFFFFF99, 0, 2, 1, 0, 0, 0);
    issue("lbu_13", OP_LBU, 32'h13, 0, 32'h000000BB, 0, 2, 1, 0, 0, 0);
    issue("lh_12",  OP_LH,  32'h12, 0, 32'hFFFFAABB, 0, 2, 1, 0, 0, 0);
    issue("lhu_10", OP_LHU, 32'h10, 0, 32'h00008899, 0, 2, 1, 0, 0, 0);

    // Reset during the write-back cycle of an SH.
    wait_idle();
    drive(OP_SH, 32'h10, 32'h0000BEEF);
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstwr.busy", {31'b0, bus.busy}, 32'h1);
    check("rstwr.mem_write", {31'b0, bus.mem_write}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstwr.busy_after", {31'b0, bus.busy}, 32'h0);
    check("rstwr.done_after", {31'b0, bus.done}, 32'h0);
    check("rstwr.rdata", bus.rdata, 32'h0);
    check("rstwr.mem", mem[4], 32'h8899AABB);

    issue("sb_12",   OP_SB, 32'h12, 32'h123456CC, 32'h0, 0, 3, 1, 1, 32'h10, 32'h8899CCBB);
    issue("lw_10",   OP_LW, 32'h10, 0, 32'h8899CCBB, 0, 2, 1, 0, 0, 0);
    issue("lw_13e",  OP_LW, 32'h13, 0, 32'h8899CCBB, 1, 1, 0, 0, 0, 0);
    issue("lh_3ffe", OP_LH, 32'h3FF, 0, 32'h8899CCBB, 1, 1, 0, 0, 0, 0);
    issue("sw_400e", OP_SW, 32'h400, 32'h1, 32'h8899CCBB, 1, 1, 0, 0, 0, 0);
    issue("sh_12",   OP_SH, 32'h12, 32'h1111BEEF, 32'h8899CCBB, 0, 3, 1, 1, 32'h10, 32'h8899BEEF);
    issue("lb_12",   OP_LB, 32'h12, 0, 32'hFFFFFFBE, 0, 2, 1, 0, 0, 0);
    issue("sw_3fc",  OP_SW, 32'h3FC, 32'hDEADBEEF, 32'hFFFFFFBE, 0, 2, 0, 1, 32'h3FC, 32'hDEADBEEF);
    issue("lw_3fc",  OP_LW, 32'h3FC, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0, 0);
    issue("lbu_3ff", OP_LBU, 32'h3FF, 0, 32'h000000EF, 0, 2, 1, 0, 0, 0);

    // req held through a busy SB, then switched to LW after its done.
    wait_idle();
    expect_txn("sb_held", 32'h000000EF, 0, 3, 1, 1, 32'h10, 32'h8855BEEF);
    expect_txn("lw_after", 32'h8855BEEF, 0, 2, 1, 0, 0, 0);
    drive(OP_SB, 32'h11, 32'h00000055);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.done && t < 20);
    bus.op = OP_LW;
    bus.addr = 32'h10;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.busy && !bus.done) && t < 4);
    bus.req = 1'b0;
    if (!bus.busy) begin
      n_vec++;
      n_miss++;
      $display("FAIL held_accept: got busy=0 expected LW accepted within 3 cycles of done");
    end

    t = 0;
    while ((sb.size() != 0 || bus.busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL pending: got %0d outstanding expected 0", sb.size());
    end
    check("final.mem", mem[4], 32'h8855BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
